sync_axis_generator: RTL

//   Generic one-axis video timing generator: a successor to the fixed vertical sync unit.

---
 rtl/sync_axis_generator.sv | 119 +++++++++++
 1 files changed

// File: rtl/sync_axis_generator.sv
// One-axis video timing generator: ACTIVE -> BACK -> SYNC -> FRONT driven by Advance pulses.
// Latency one clock, all outputs registered; optional SYNC_TIMING_LATCH_EN freezes lengths per period.
module sync_axis_generator #(
    parameter int WIDTH           = 10,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Advance,
    input  logic [WIDTH-1:0] ActiveVideo,
    input  logic [WIDTH-1:0] BackPorch,
    input  logic [WIDTH-1:0] SynchPulse,
    input  logic [WIDTH-1:0] FrontPorch,
    output logic             sync,
    output logic             active,
    output logic [WIDTH-1:0] position,
    output logic [1:0]       segment,
    output logic             PeriodEnd
);

    typedef enum logic [1:0] {
        SEG_ACTIVE = 2'b00,
        SEG_BACK   = 2'b01,
        SEG_SYNC   = 2'b10,
        SEG_FRONT  = 2'b11
    } seg_e;

    seg_e             seg_q, seg_d, nxt_seg;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_len, last_idx;
    logic             wrap_d;
    logic             found;
    logic [1:0]       probe;
    logic [WIDTH-1:0] len_a, len_b, len_s, len_f;
    logic [WIDTH-1:0] len_v [4];

`ifdef SYNC_TIMING_LATCH_EN
    logic [WIDTH-1:0] len_a_q, len_b_q, len_s_q, len_f_q;

    // Shadows reload on the wrap edge, so the new period starts with fresh lengths.
    always_ff @(posedge clock) begin
        if (reset || wrap_d) begin
            len_a_q <= ActiveVideo;
            len_b_q <= BackPorch;
            len_s_q <= SynchPulse;
            len_f_q <= FrontPorch;
        end
    end

    assign len_a = len_a_q;
    assign len_b = len_b_q;
    assign len_s = len_s_q;
    assign len_f = len_f_q;
`else
    assign len_a = ActiveVideo;
    assign len_b = BackPorch;
    assign len_s = SynchPulse;
    assign len_f = FrontPorch;
`endif

    always_comb begin
        len_v[0] = len_a;
        len_v[1] = len_b;
        len_v[2] = len_s;
        len_v[3] = len_f;
    end

    // A zero length yields last index 0, so the segment is left on the next step without wrapping.
    always_comb begin
        cur_len  = len_v[seg_q];
        last_idx = (cur_len == '0) ? '0 : cur_len - WIDTH'(1);

        nxt_seg = SEG_ACTIVE;
        found   = 1'b0;
        probe   = 2'b00;
        for (int k = 1; k < 4; k++) begin
            probe = seg_q + k[1:0];
            if (!found && (probe == 2'b00 || len_v[probe] != '0)) begin
                nxt_seg = seg_e'(probe);
                found   = 1'b1;
            end
        end

        seg_d  = seg_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (Advance) begin
            if (cnt_q < last_idx) begin
                cnt_d = cnt_q + WIDTH'(1);
            end else begin
                cnt_d  = '0;
                seg_d  = nxt_seg;
                wrap_d = (nxt_seg == SEG_ACTIVE);
            end
        end
    end

    // Flags decode from next state so they change on the same edge as segment.
    always_ff @(posedge clock) begin
        if (reset) begin
            seg_q     <= SEG_ACTIVE;
            cnt_q     <= '0;
            position  <= '0;
            active    <= 1'b1;
            sync      <= SYNC_ACTIVE_LOW;
            PeriodEnd <= 1'b0;
        end else begin
            seg_q     <= seg_d;
            cnt_q     <= cnt_d;
            position  <= (seg_d == SEG_ACTIVE) ? cnt_d : '0;
            active    <= (seg_d == SEG_ACTIVE);
            sync      <= (seg_d == SEG_SYNC) ? ~SYNC_ACTIVE_LOW : SYNC_ACTIVE_LOW;
            PeriodEnd <= wrap_d;
        end
    end

    assign segment = seg_q;

endmodule
